// File: rtl/core_test_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_test_pkg
// Purpose  : Shared types and helpers for the core test sequencer: FSM state
//            encoding, LFSR polynomial/step function and the operand/product
//            byte-address map of a test pair.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package core_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_LAUNCH = 3'd3,
    S_WAIT   = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6
  } seq_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Selectors for pair_addr.
  localparam int SEL_OP_A    = 0;
  localparam int SEL_OP_B    = 1;
  localparam int SEL_PRODUCT = 2;

  // Right-shift Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  // First byte address of operand A, operand B or the product of pair i.
  // Operands of consecutive pairs are packed from address 0; products are
  // laid out with the same stride starting at res_base.
  function automatic int pair_addr(input int i, input int which,
                                   input int nbytes, input int res_base);
    case (which)
      SEL_OP_A: return i * 2 * nbytes;
      SEL_OP_B: return i * 2 * nbytes + nbytes;
      default:  return res_base + i * 2 * nbytes;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_test_sequencer_lfsr32.sv
`default_nettype none
// ============================================================================
// Module   : lfsr32
// Purpose  : 32-bit right-shift Galois LFSR with synchronous load and step.
//            A zero seed is replaced by 1 so the register never locks up.
// Ports    : clk_i   - clock
//            rst_i   - synchronous active-high reset (state -> 1)
//            load_i  - load seed_i (priority over step_i)
//            seed_i  - load value
//            step_i  - advance one step
//            state_o - current LFSR state
// Revision : 1.0  initial release
// ============================================================================
module lfsr32
  import core_test_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= 32'd1;
    end else if (load_i) begin
      state_q <= (seed_i == 32'd0) ? 32'd1 : seed_i;
    end else if (step_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/core_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_test_sequencer
// Purpose  : On-chip self-checking multiply test. Clears data memory
//            (optional), loads pseudo-random signed operand pairs, releases
//            the core, waits for done with a timeout, then reads back every
//            product and compares it with a local signed multiply.
// Ports    : clk_i / rst_i           - clock, synchronous active-high reset
//            go_i, seed_i            - start a run with the given LFSR seed
//            core_start_o/core_done_i- core hold/release and completion
//            mem_sel_o               - 1 = sequencer owns the data memory
//            mem_we_o/addr/wdata/rdata - byte port, combinational read
//            busy_o, run_done_o      - run in progress / run finished
//            timed_out_o             - core did not finish in TIMEOUT_CYC
//            pass_count_o, fail_count_o, first_fail_o, cycles_o - results
// Revision : 1.0  initial release
// ============================================================================
module core_test_sequencer
  import core_test_pkg::*;
#(
  parameter int OP_W        = 16,
  parameter int N_PAIRS     = 15,
  parameter int ADDR_W      = 8,
  parameter int RES_BASE    = 60,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CLEAR_EN    = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         go_i,
  input  logic [31:0]                  seed_i,
  output logic                         core_start_o,
  input  logic                         core_done_i,
  output logic                         mem_sel_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [7:0]                   mem_wdata_o,
  input  logic [7:0]                   mem_rdata_i,
  output logic                         busy_o,
  output logic                         run_done_o,
  output logic                         timed_out_o,
  output logic [$clog2(N_PAIRS+1)-1:0] pass_count_o,
  output logic [$clog2(N_PAIRS+1)-1:0] fail_count_o,
  output logic [$clog2(N_PAIRS)-1:0]   first_fail_o,
  output logic [31:0]                  cycles_o
);

  localparam int NB     = OP_W / 8;
  localparam int CNT_W  = $clog2(N_PAIRS + 1);
  localparam int PI_W   = $clog2(N_PAIRS);
  localparam int CB_W   = $clog2(4 * NB + 1);
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(2 * NB * N_PAIRS - 1);
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYC - 1);

  seq_state_t          state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;
  logic                timed_out_q;
  logic [CNT_W-1:0]    pass_q, fail_q;
  logic [PI_W-1:0]     first_fail_q;
  logic [31:0]         cycles_q;
  logic [PI_W-1:0]     chk_pair_q;
  logic [CB_W-1:0]     chk_byte_q;
  logic [4*OP_W-1:0]   sh_q;

  // Address of byte k (0 .. 4*NB-1) in the read-back sequence of pair i:
  // both operands first, then the product.
  function automatic logic [ADDR_W-1:0] chk_addr(input int i, input int k);
    int a;
    if (k < 2 * NB) a = pair_addr(i, SEL_OP_A, NB, RES_BASE) + k;
    else            a = pair_addr(i, SEL_PRODUCT, NB, RES_BASE) + k - 2 * NB;
    return ADDR_W'(a);
  endfunction

  // ---------------------------------------------------------------- LFSR
  logic        w_go_ok, w_lfsr_step;
  logic [31:0] w_lfsr_q, w_lfsr_nxt, w_seed_fix, w_lfsr_seed;

  assign w_go_ok    = go_i && (state_q == S_IDLE || state_q == S_DONE);
  assign w_seed_fix = (seed_i == 32'd0) ? 32'd1 : seed_i;
  // Without a clear phase the first load byte is written on the cycle right
  // after go, so the seed is loaded already advanced by one step.
  assign w_lfsr_seed = (CLEAR_EN != 0) ? w_seed_fix : lfsr_next(w_seed_fix);
  assign w_lfsr_nxt  = lfsr_next(w_lfsr_q);
  assign w_lfsr_step = (state_q == S_CLEAR && (&mem_addr_q)) ||
                       (state_q == S_LOAD  && mem_addr_q != LOAD_LAST);

  lfsr32 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (w_go_ok),
    .seed_i  (w_lfsr_seed),
    .step_i  (w_lfsr_step),
    .state_o (w_lfsr_q)
  );

  // ------------------------------------------------------------- compare
  logic [OP_W-1:0]          w_op_a, w_op_b;
  logic [2*OP_W-1:0]        w_prod_rd;
  logic signed [2*OP_W-1:0] w_a_ext, w_b_ext, w_prod_ref;
  logic                     w_match;

  assign w_op_a     = sh_q[4*OP_W-1 -: OP_W];
  assign w_op_b     = sh_q[3*OP_W-1 -: OP_W];
  assign w_prod_rd  = sh_q[2*OP_W-1:0];
  // Sign-extend before multiplying so the truncated product is the full
  // 2*OP_W-bit signed result.
  assign w_a_ext    = {{OP_W{w_op_a[OP_W-1]}}, w_op_a};
  assign w_b_ext    = {{OP_W{w_op_b[OP_W-1]}}, w_op_b};
  assign w_prod_ref = w_a_ext * w_b_ext;
  assign w_match    = (w_prod_rd == w_prod_ref);

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      timed_out_q  <= 1'b0;
      pass_q       <= '0;
      fail_q       <= '0;
      first_fail_q <= '0;
      cycles_q     <= '0;
      chk_pair_q   <= '0;
      chk_byte_q   <= '0;
      sh_q         <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (go_i) begin
            timed_out_q  <= 1'b0;
            pass_q       <= '0;
            fail_q       <= '0;
            first_fail_q <= '0;
            cycles_q     <= '0;
            mem_addr_q   <= '0;
            if (CLEAR_EN != 0) begin
              state_q     <= S_CLEAR;
              mem_wdata_q <= '0;
            end else begin
              state_q     <= S_LOAD;
              mem_wdata_q <= w_lfsr_seed[7:0];
            end
          end
        end
        S_CLEAR: begin
          if (&mem_addr_q) begin
            state_q     <= S_LOAD;
            mem_addr_q  <= '0;
            mem_wdata_q <= w_lfsr_nxt[7:0];
          end else begin
            mem_addr_q  <= mem_addr_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (mem_addr_q == LOAD_LAST) begin
            state_q    <= S_LAUNCH;
            mem_addr_q <= '0;
          end else begin
            mem_addr_q  <= mem_addr_q + 1'b1;
            mem_wdata_q <= w_lfsr_nxt[7:0];
          end
        end
        S_LAUNCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (core_done_i) begin
            state_q    <= S_CHECK;
            chk_pair_q <= '0;
            chk_byte_q <= '0;
            mem_addr_q <= chk_addr(0, 0);
          end else begin
            cycles_q <= cycles_q + 32'd1;
            if (cycles_q == TO_LAST) begin
              timed_out_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_CHECK: begin
          if (chk_byte_q != CB_W'(4 * NB)) begin
            // Read cycle: capture the byte addressed this cycle, present next.
            sh_q       <= {sh_q[4*OP_W-9:0], mem_rdata_i};
            chk_byte_q <= chk_byte_q + 1'b1;
            mem_addr_q <= chk_addr(int'(chk_pair_q), int'(chk_byte_q) + 1);
          end else begin
            if (w_match) begin
              pass_q <= pass_q + 1'b1;
            end else begin
              fail_q <= fail_q + 1'b1;
              if (fail_q == '0) first_fail_q <= chk_pair_q;
            end
            chk_byte_q <= '0;
            if (chk_pair_q == PI_W'(N_PAIRS - 1)) begin
              state_q <= S_DONE;
            end else begin
              chk_pair_q <= chk_pair_q + 1'b1;
              mem_addr_q <= chk_addr(int'(chk_pair_q) + 1, 0);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control outputs decode directly from the registered state.
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign run_done_o   = (state_q == S_DONE);
  assign core_start_o = !(state_q == S_LAUNCH || state_q == S_WAIT);
  assign mem_sel_o    = core_start_o;
  assign mem_we_o     = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign timed_out_o  = timed_out_q;
  assign pass_count_o = pass_q;
  assign fail_count_o = fail_q;
  assign first_fail_o = first_fail_q;
  assign cycles_o     = cycles_q;

endmodule
`default_nettype wire

// File: doc/core_test_sequencer.md
Name: core_test_sequencer

Overview:
- Synthesizable on-chip successor to the processor's multiply test fixture.
- Runs one self-checking pass: optionally clears data memory, loads N_PAIRS pseudo-random signed operand pairs, holds the core in start, then releases it.
- Waits for done with a timeout, reads back the products and compares each against an internal signed multiply.
- Reports pass/fail counts, the first failing pair index and the core run length; sits beside TopLevel and muxes onto the data-memory port.

Parameters:
- OP_W, 16: operand width in bits; multiple of 8; B = OP_W/8 bytes per operand.
- N_PAIRS, 15: number of operand pairs per run.
- ADDR_W, 8: data-memory address width.
- RES_BASE, 60: byte address of the first product; must be >= N_PAIRS*2*B.
- TIMEOUT_CYC, 100000: maximum core run cycles.
- CLEAR_EN, 1: 1 = zero all 2^ADDR_W bytes before loading.

Ports:
- CLK  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- go  in  1  start a run; sampled only in IDLE or DONE.
- seed  in  32  LFSR seed, captured on an accepted go; 0 is replaced by 1.
- core_start  out  1  drives TopLevel start; 1 holds the core.
- core_done  in  1  TopLevel done.
- mem_sel  out  1  1 = sequencer owns data memory; 0 = core owns it.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; combinational (same-cycle) read.
- busy  out  1  high in every state except IDLE and DONE.
- run_done  out  1  high in DONE.
- timed_out  out  1  set when the run hit TIMEOUT_CYC.
- pass_count  out  $clog2(N_PAIRS+1)  number of matching pairs.
- fail_count  out  $clog2(N_PAIRS+1)  number of mismatching pairs.
- first_fail  out  $clog2(N_PAIRS)  index of the lowest failing pair; valid when fail_count != 0.
- cycles  out  32  core run cycles, counted from the first WAIT cycle up to but excluding the core_done cycle.

Behaviour:
- Reset values: state IDLE; core_start=1, mem_sel=1, mem_we=0, mem_addr=0, mem_wdata=0; busy, run_done, timed_out=0; counters, first_fail and cycles = 0.
- Reset mid-run: same values on the next edge. Memory contents are left as they are.
- States: IDLE -> CLEAR -> LOAD -> LAUNCH -> WAIT -> CHECK -> DONE. CLEAR is skipped when CLEAR_EN=0.
- Accepted go (IDLE or DONE):
  - Capture seed.
  - Zero pass_count, fail_count, first_fail, cycles and timed_out.
  - go during busy is ignored.
- CLEAR: writes 0 to address k on cycle k, for k = 0 .. 2^ADDR_W-1. One write per cycle, mem_we=1.
- LOAD: runs 2*B*N_PAIRS cycles, one byte per cycle.
  - Each cycle: step the LFSR once, then write its low byte.
  - Pair i: A at bytes i*2B .. i*2B+B-1, B at the following B bytes.
  - Byte order is big-endian (MS byte at the lowest address).
- LFSR: 32-bit right-shift Galois, polynomial 0x80200003.
  - next = (s>>1) ^ (s[0] ? 0x80200003 : 0).
- LAUNCH: one cycle.
  - core_start=0, mem_sel=0, mem_we=0.
  - core_done is not sampled.
- WAIT:
  - core_start=0, mem_sel=0.
  - cycles increments each cycle that core_done=0.
  - core_done=1: go to CHECK; mem_sel=1 and core_start=1 from the next cycle.
  - cycles reaches TIMEOUT_CYC: set timed_out=1 and go to DONE; no check is performed and counters stay 0.
- CHECK, per pair (4B+1 cycles):
  - Read 2B operand bytes, then 2B product bytes at RES_BASE + i*2B (big-endian, 2*OP_W bits).
  - Compare cycle: product == signed(A)*signed(B) as a full 2*OP_W-bit result.
  - Match: pass_count++. Mismatch: fail_count++; first_fail is loaded only on the first mismatch.
- DONE:
  - run_done=1, core_start=1, mem_sel=1.
  - All status outputs hold until an accepted go or Reset.
- A core_done that is still high from a previous run is ignored, because it is sampled only in WAIT.

Decomposition:
- Package core_test_pkg:
  - state enum seq_state_t.
  - LFSR_POLY constant.
  - function lfsr_next.
  - function pair_addr(i, which) returning the byte address.
- Sub-module lfsr32 (load, seed, step, state), reused by later benches.

Test Plan:
1. Reset, seed=1, go; CLEAR_EN=1 -> 256 clear writes, then mem[0]=0x03 and mem[1]=0x02. LOAD lasts exactly 60 cycles.
2. Behavioural core that multiplies correctly and raises done 200 cycles after start falls -> pass_count=15, fail_count=0, cycles=200, run_done=1.
3. Same core with product bit 0 of pair 3 and pair 9 flipped -> pass_count=13, fail_count=2, first_fail=3.
4. Core never raises done, TIMEOUT_CYC=50 -> timed_out=1 exactly 50 WAIT cycles after LAUNCH; pass_count=fail_count=0; core_start=1.
5. seed=0 -> identical memory image to seed=1. A go pulsed during LOAD is ignored and the run completes unchanged.
6. Reset asserted mid-LOAD -> next cycle: IDLE, mem_we=0, core_start=1, busy=0. A following go restarts from CLEAR.
